// File: rtl/mem_arb_if.sv
// Memory bus port shared by the arbiter: a valid/ready address phase
// followed by an rvalid response phase.
interface mem_arb_if;
  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned MW = 8;
  localparam int unsigned SW = 2;

  logic          bus_valid;
  logic          bus_ready;
  logic [AW-1:0] bus_addr;
  logic          bus_wen;
  logic [SW-1:0] bus_size;
  logic [DW-1:0] bus_wdata;
  logic [MW-1:0] bus_wmask;
  logic          bus_rvalid;
  logic [DW-1:0] bus_rdata;

  modport master (
    output bus_valid, bus_addr, bus_wen, bus_size, bus_wdata, bus_wmask,
    input  bus_ready, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_valid, bus_addr, bus_wen, bus_size, bus_wdata, bus_wmask,
    output bus_ready, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/mem_arb.sv
// Arbiter sharing one memory bus between instruction fetch and the LSU:
// alternating priority under contention, one outstanding access, response timeout.
module mem_arb #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic        if_rsp_valid,
  output logic [63:0] if_rsp_rdata,
  output logic        if_rsp_err,
  input  logic        lsu_req,
  input  logic [63:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [1:0]  lsu_size,
  input  logic [63:0] lsu_wdata,
  input  logic [7:0]  lsu_wmask,
  output logic        lsu_rsp_valid,
  output logic [63:0] lsu_rsp_rdata,
  output logic        lsu_rsp_err,
  mem_arb_if.master   bus,
  output logic        arb_busy
);
  localparam int unsigned AW    = 64;
  localparam int unsigned DW    = 64;
  localparam int unsigned MW    = 8;
  localparam int unsigned SW    = 2;
  localparam int unsigned CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [SW-1:0]    SIZE_WORD = SW'(2);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WAIT, S_RESP} state_e;
  typedef enum logic {OWN_IF, OWN_LSU} owner_e;

  state_e           state_q;
  owner_e           owner_q;
  owner_e           last_owner_q;
  logic [CNT_W-1:0] cnt_q;
  logic             bus_valid_q;
  logic [AW-1:0]    bus_addr_q;
  logic             bus_wen_q;
  logic [SW-1:0]    bus_size_q;
  logic [DW-1:0]    bus_wdata_q;
  logic [MW-1:0]    bus_wmask_q;
  logic             if_rsp_valid_q;
  logic             lsu_rsp_valid_q;
  logic [DW-1:0]    rsp_rdata_q;
  logic             rsp_err_q;
  logic             busy_q;

  logic grant_lsu_c;
  logic timeout_hit_c;

  // LSU wins contention unless it owned the last completed grant.
  assign grant_lsu_c   = lsu_req && (!if_req || (last_owner_q == OWN_IF));
  assign timeout_hit_c = (TIMEOUT != 0) && (cnt_q == TIMEOUT_C);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      owner_q         <= OWN_IF;
      last_owner_q    <= OWN_IF;
      cnt_q           <= '0;
      bus_valid_q     <= 1'b0;
      bus_addr_q      <= '0;
      bus_wen_q       <= 1'b0;
      bus_size_q      <= '0;
      bus_wdata_q     <= '0;
      bus_wmask_q     <= '0;
      if_rsp_valid_q  <= 1'b0;
      lsu_rsp_valid_q <= 1'b0;
      rsp_rdata_q     <= '0;
      rsp_err_q       <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      if_rsp_valid_q  <= 1'b0;
      lsu_rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (if_req || lsu_req) begin
            state_q     <= S_ADDR;
            bus_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            if (grant_lsu_c) begin
              owner_q     <= OWN_LSU;
              bus_addr_q  <= lsu_addr;
              bus_wen_q   <= lsu_wen;
              bus_size_q  <= lsu_size;
              bus_wdata_q <= lsu_wdata;
              bus_wmask_q <= lsu_wmask;
            end else begin
              owner_q     <= OWN_IF;
              bus_addr_q  <= if_addr;
              bus_wen_q   <= 1'b0;
              bus_size_q  <= SIZE_WORD;
              bus_wdata_q <= '0;
              bus_wmask_q <= '0;
            end
          end
        end
        S_ADDR: begin
          // Address phase is held until accepted; no timeout here.
          if (bus.bus_ready) begin
            bus_valid_q <= 1'b0;
            if (bus.bus_rvalid) begin
              state_q         <= S_RESP;
              rsp_rdata_q     <= bus.bus_rdata;
              rsp_err_q       <= 1'b0;
              if_rsp_valid_q  <= (owner_q == OWN_IF);
              lsu_rsp_valid_q <= (owner_q == OWN_LSU);
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= '0;
            end
          end
        end
        S_WAIT: begin
          if (bus.bus_rvalid) begin
            state_q         <= S_RESP;
            rsp_rdata_q     <= bus.bus_rdata;
            rsp_err_q       <= 1'b0;
            if_rsp_valid_q  <= (owner_q == OWN_IF);
            lsu_rsp_valid_q <= (owner_q == OWN_LSU);
          end else if (timeout_hit_c) begin
            state_q         <= S_RESP;
            rsp_rdata_q     <= '0;
            rsp_err_q       <= 1'b1;
            if_rsp_valid_q  <= (owner_q == OWN_IF);
            lsu_rsp_valid_q <= (owner_q == OWN_LSU);
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_RESP: begin
          state_q      <= S_IDLE;
          last_owner_q <= owner_q;
          busy_q       <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.bus_valid = bus_valid_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wen   = bus_wen_q;
  assign bus.bus_size  = bus_size_q;
  assign bus.bus_wdata = bus_wdata_q;
  assign bus.bus_wmask = bus_wmask_q;

  assign if_rsp_valid  = if_rsp_valid_q;
  assign if_rsp_rdata  = rsp_rdata_q;
  assign if_rsp_err    = rsp_err_q;
  assign lsu_rsp_valid = lsu_rsp_valid_q;
  assign lsu_rsp_rdata = rsp_rdata_q;
  assign lsu_rsp_err   = rsp_err_q;
  assign arb_busy      = busy_q;
endmodule

// File: tb/tb_mem_arb.sv
// Scenario bench for mem_arb: expected responses are queued at stimulus time
// and popped when the arbiter answers.
module tb_mem_arb;
  localparam int unsigned TO = 4;

  typedef struct packed {
    logic        lsu;
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_rsp_valid;
  logic [63:0] if_rsp_rdata;
  logic        if_rsp_err;
  logic        lsu_req;
  logic [63:0] lsu_addr;
  logic        lsu_wen;
  logic [1:0]  lsu_size;
  logic [63:0] lsu_wdata;
  logic [7:0]  lsu_wmask;
  logic        lsu_rsp_valid;
  logic [63:0] lsu_rsp_rdata;
  logic        lsu_rsp_err;
  logic        arb_busy;

  mem_arb_if bus_if ();

  mem_arb #(.TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .if_req        (if_req),
    .if_addr       (if_addr),
    .if_rsp_valid  (if_rsp_valid),
    .if_rsp_rdata  (if_rsp_rdata),
    .if_rsp_err    (if_rsp_err),
    .lsu_req       (lsu_req),
    .lsu_addr      (lsu_addr),
    .lsu_wen       (lsu_wen),
    .lsu_size      (lsu_size),
    .lsu_wdata     (lsu_wdata),
    .lsu_wmask     (lsu_wmask),
    .lsu_rsp_valid (lsu_rsp_valid),
    .lsu_rsp_rdata (lsu_rsp_rdata),
    .lsu_rsp_err   (lsu_rsp_err),
    .bus           (bus_if),
    .arb_busy      (arb_busy)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];

  // Observations from the most recent serve() call.
  logic        r_done, r_if, r_lsu, r_err, r_pulse_ok, r_stable;
  logic [63:0] r_rdata;
  int          r_cyc, r_vld;
  logic [63:0] s_addr, s_wdata;
  logic        s_wen;
  logic [1:0]  s_size;
  logic [7:0]  s_wmask;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Plays the bus side for one access whose request is sampled at the next edge.
  // rdy_dly: ADDR cycles before bus_ready; rv_dly: cycles from ready to rvalid (<0 = never).
  task automatic serve(input int rdy_dly, input int rv_dly, input logic [63:0] rd);
    r_done = 1'b0; r_if = 1'b0; r_lsu = 1'b0; r_err = 1'b0; r_rdata = '0;
    r_pulse_ok = 1'b0; r_stable = 1'b1; r_cyc = 0; r_vld = 0;
    tick();
    s_addr  = bus_if.bus_addr;
    s_wen   = bus_if.bus_wen;
    s_size  = bus_if.bus_size;
    s_wdata = bus_if.bus_wdata;
    s_wmask = bus_if.bus_wmask;
    for (int i = 0; i < 40 && !r_done; i++) begin
      if (if_rsp_valid || lsu_rsp_valid) begin
        r_done  = 1'b1;
        r_if    = if_rsp_valid;
        r_lsu   = lsu_rsp_valid;
        r_cyc   = i + 1;
        r_rdata = if_rsp_valid ? if_rsp_rdata : lsu_rsp_rdata;
        r_err   = if_rsp_valid ? if_rsp_err : lsu_rsp_err;
      end else begin
        if (bus_if.bus_valid) begin
          r_vld++;
          if ({bus_if.bus_addr, bus_if.bus_wen, bus_if.bus_size, bus_if.bus_wdata, bus_if.bus_wmask}
              !== {s_addr, s_wen, s_size, s_wdata, s_wmask}) r_stable = 1'b0;
        end
        bus_if.bus_ready  = (i == rdy_dly);
        bus_if.bus_rvalid = (rv_dly >= 0) && (i == rdy_dly + rv_dly);
        bus_if.bus_rdata  = bus_if.bus_rvalid ? rd : {$urandom, $urandom};
        tick();
      end
    end
    bus_if.bus_ready  = 1'b0;
    bus_if.bus_rvalid = 1'b0;
    if (r_done) begin
      tick();
      r_pulse_ok = !if_rsp_valid && !lsu_rsp_valid && !arb_busy;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if ({bus_if.bus_valid, bus_if.bus_addr, bus_if.bus_wen, bus_if.bus_size,
         bus_if.bus_wdata, bus_if.bus_wmask} !== '0) begin
      bad++;
      $display("FAIL reset_bus: got valid=%b addr=%h size=%0d required all zero",
               bus_if.bus_valid, bus_if.bus_addr, bus_if.bus_size);
    end
    total++;
    if ({if_rsp_valid, if_rsp_rdata, if_rsp_err, lsu_rsp_valid, lsu_rsp_rdata,
         lsu_rsp_err, arb_busy} !== '0) begin
      bad++;
      $display("FAIL reset_rsp: got ifv=%b lsuv=%b busy=%b rdata=%h required all zero",
               if_rsp_valid, lsu_rsp_valid, arb_busy, if_rsp_rdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_if_fetch();
    exp_t e;
    if_req  = 1'b1;
    if_addr = 64'h0000_0000_8000_0000;
    sb_q.push_back('{lsu: 1'b0, rdata: 64'h0000_0013_0000_0093, err: 1'b0});
    serve(0, 2, 64'h0000_0013_0000_0093);
    if_req = 1'b0;
    e = sb_q.pop_front();
    total++;
    if ({r_done, r_lsu, r_if, r_rdata, r_err} !== {1'b1, e.lsu, !e.lsu, e.rdata, e.err}) begin
      bad++;
      $display("FAIL if_fetch_rsp: got done=%b if=%b lsu=%b rdata=%h err=%b required if rdata=%h err=%b",
               r_done, r_if, r_lsu, r_rdata, r_err, e.rdata, e.err);
    end
    total++;
    if (r_cyc !== 4) begin
      bad++;
      $display("FAIL if_fetch_latency: got cycle %0d required 4", r_cyc);
    end
    total++;
    if ({s_addr, s_wen, s_size, s_wdata, s_wmask} !== {64'h8000_0000, 1'b0, 2'd2, 64'h0, 8'h0}) begin
      bad++;
      $display("FAIL if_fetch_fields: got addr=%h wen=%b size=%0d wdata=%h wmask=%h required 80000000/0/2/0/0",
               s_addr, s_wen, s_size, s_wdata, s_wmask);
    end
    total++;
    if (r_pulse_ok !== 1'b1) begin
      bad++;
      $display("FAIL if_fetch_pulse: got pulse_ok=%b required 1", r_pulse_ok);
    end
  endtask

  task automatic test_lsu_store();
    exp_t e;
    lsu_req   = 1'b1;
    lsu_addr  = 64'h0000_0000_8000_1008;
    lsu_wen   = 1'b1;
    lsu_size  = 2'd3;
    lsu_wdata = 64'hDEAD_BEEF_CAFE_F00D;
    lsu_wmask = 8'hFF;
    sb_q.push_back('{lsu: 1'b1, rdata: 64'h0000_0000_0000_5A5A, err: 1'b0});
    serve(3, 1, 64'h0000_0000_0000_5A5A);
    lsu_req = 1'b0;
    e = sb_q.pop_front();
    total++;
    if ({r_done, r_lsu, r_if, r_rdata, r_err} !== {1'b1, e.lsu, !e.lsu, e.rdata, e.err}) begin
      bad++;
      $display("FAIL lsu_store_rsp: got done=%b if=%b lsu=%b rdata=%h err=%b required lsu rdata=%h err=%b",
               r_done, r_if, r_lsu, r_rdata, r_err, e.rdata, e.err);
    end
    total++;
    if ({s_addr, s_wen, s_size, s_wdata, s_wmask}
        !== {64'h8000_1008, 1'b1, 2'd3, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF}) begin
      bad++;
      $display("FAIL lsu_store_fields: got addr=%h wen=%b size=%0d wdata=%h wmask=%h required 80001008/1/3/deadbeefcafef00d/ff",
               s_addr, s_wen, s_size, s_wdata, s_wmask);
    end
    total++;
    if ({r_vld, r_stable} !== {32'd4, 1'b1}) begin
      bad++;
      $display("FAIL lsu_store_hold: got valid_cycles=%0d stable=%b required 4 and 1", r_vld, r_stable);
    end
    total++;
    if (r_cyc !== 6) begin
      bad++;
      $display("FAIL lsu_store_latency: got cycle %0d required 6", r_cyc);
    end
  endtask

  task automatic test_zero_wait();
    exp_t e;
    if_req  = 1'b1;
    if_addr = 64'h0000_0000_8000_0040;
    sb_q.push_back('{lsu: 1'b0, rdata: 64'h1111_2222_3333_4444, err: 1'b0});
    serve(0, 0, 64'h1111_2222_3333_4444);
    if_req = 1'b0;
    e = sb_q.pop_front();
    total++;
    if ({r_done, r_lsu, r_if, r_rdata, r_err} !== {1'b1, e.lsu, !e.lsu, e.rdata, e.err}) begin
      bad++;
      $display("FAIL zero_wait_rsp: got done=%b if=%b rdata=%h err=%b required if rdata=%h",
               r_done, r_if, r_rdata, r_err, e.rdata);
    end
    total++;
    if ({r_cyc, r_pulse_ok} !== {32'd2, 1'b1}) begin
      bad++;
      $display("FAIL zero_wait_latency: got cycle=%0d pulse_ok=%b required 2 and 1", r_cyc, r_pulse_ok);
    end
  endtask

  task automatic test_contention();
    exp_t e;
    logic st_if[7]   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic st_lsu[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic exp_lsu[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [63:0] d;
    if_addr  = 64'h0000_0000_8000_0100;
    lsu_addr = 64'h0000_0000_8000_2000;
    lsu_wen  = 1'b0;
    lsu_size = 2'd3;
    if_req   = 1'b1;
    lsu_req  = 1'b1;
    rst      = 1'b1;
    tick();
    rst      = 1'b0;
    for (int s = 0; s < 7; s++) begin
      if_req  = st_if[s];
      lsu_req = st_lsu[s];
      d = 64'hC0DE_0000_0000_0000 + 64'(s);
      sb_q.push_back('{lsu: exp_lsu[s], rdata: d, err: 1'b0});
      serve(0, 0, d);
      e = sb_q.pop_front();
      total++;
      if ({r_done, r_lsu, r_if, r_rdata, s_addr}
          !== {1'b1, e.lsu, !e.lsu, e.rdata, (e.lsu ? lsu_addr : if_addr)}) begin
        bad++;
        $display("FAIL contention_step%0d: got done=%b lsu=%b if=%b rdata=%h addr=%h required lsu=%b rdata=%h",
                 s, r_done, r_lsu, r_if, r_rdata, s_addr, e.lsu, e.rdata);
      end
    end
    if_req  = 1'b0;
    lsu_req = 1'b0;
  endtask

  task automatic test_timeout();
    exp_t e;
    logic quiet = 1'b1;
    lsu_req  = 1'b1;
    lsu_addr = 64'h0000_0000_8000_3000;
    lsu_wen  = 1'b0;
    lsu_size = 2'd2;
    sb_q.push_back('{lsu: 1'b1, rdata: 64'h0, err: 1'b1});
    serve(0, -1, 64'h0);
    lsu_req = 1'b0;
    e = sb_q.pop_front();
    total++;
    if ({r_done, r_lsu, r_if, r_rdata, r_err} !== {1'b1, e.lsu, !e.lsu, e.rdata, e.err}) begin
      bad++;
      $display("FAIL timeout_rsp: got done=%b lsu=%b rdata=%h err=%b required lsu rdata=0 err=1",
               r_done, r_lsu, r_rdata, r_err);
    end
    total++;
    if ({r_cyc, r_pulse_ok} !== {32'(2 + TO + 1), 1'b1}) begin
      bad++;
      $display("FAIL timeout_latency: got cycle=%0d pulse_ok=%b required %0d and 1",
               r_cyc, r_pulse_ok, 2 + TO + 1);
    end
    bus_if.bus_rvalid = 1'b1;
    bus_if.bus_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
    tick();
    bus_if.bus_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (if_rsp_valid || lsu_rsp_valid || arb_busy || bus_if.bus_valid) quiet = 1'b0;
      tick();
    end
    total++;
    if (quiet !== 1'b1) begin
      bad++;
      $display("FAIL timeout_late_rvalid: got activity=%b required 0", !quiet);
    end
    if_req  = 1'b1;
    if_addr = 64'h0000_0000_8000_0200;
    sb_q.push_back('{lsu: 1'b0, rdata: 64'h0000_0000_0000_0013, err: 1'b0});
    serve(0, 1, 64'h0000_0000_0000_0013);
    if_req = 1'b0;
    e = sb_q.pop_front();
    total++;
    if ({r_done, r_lsu, r_if, r_rdata, r_err, r_cyc}
        !== {1'b1, e.lsu, !e.lsu, e.rdata, e.err, 32'd3}) begin
      bad++;
      $display("FAIL timeout_recover: got done=%b if=%b rdata=%h err=%b cycle=%0d required if rdata=%h err=0 cycle=3",
               r_done, r_if, r_rdata, r_err, r_cyc, e.rdata);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    logic quiet = 1'b1;
    lsu_req  = 1'b1;
    lsu_addr = 64'h0000_0000_8000_4000;
    lsu_wen  = 1'b0;
    lsu_size = 2'd3;
    sb_q.push_back('{lsu: 1'b1, rdata: 64'h7777_8888_9999_AAAA, err: 1'b0});
    serve(0, 0, 64'h7777_8888_9999_AAAA);
    lsu_req = 1'b0;
    e = sb_q.pop_front();
    total++;
    if ({r_done, r_lsu, r_rdata} !== {1'b1, e.lsu, e.rdata}) begin
      bad++;
      $display("FAIL reset_mid_pre: got done=%b lsu=%b rdata=%h required lsu rdata=%h",
               r_done, r_lsu, r_rdata, e.rdata);
    end
    if_req  = 1'b1;
    if_addr = 64'h0000_0000_8000_0300;
    tick();
    bus_if.bus_ready = 1'b1;
    tick();
    bus_if.bus_ready = 1'b0;
    tick();
    total++;
    if ({arb_busy, bus_if.bus_valid} !== 2'b10) begin
      bad++;
      $display("FAIL reset_mid_inwait: got busy=%b valid=%b required 1 and 0", arb_busy, bus_if.bus_valid);
    end
    rst    = 1'b1;
    if_req = 1'b0;
    tick();
    rst    = 1'b0;
    total++;
    if ({bus_if.bus_valid, bus_if.bus_addr, bus_if.bus_wen, bus_if.bus_size, bus_if.bus_wdata,
         bus_if.bus_wmask, if_rsp_valid, if_rsp_rdata, if_rsp_err, lsu_rsp_valid,
         lsu_rsp_rdata, lsu_rsp_err, arb_busy} !== '0) begin
      bad++;
      $display("FAIL reset_mid_zero: got valid=%b addr=%h busy=%b rdata=%h required all zero",
               bus_if.bus_valid, bus_if.bus_addr, arb_busy, lsu_rsp_rdata);
    end
    bus_if.bus_rvalid = 1'b1;
    bus_if.bus_rdata  = 64'hDEAD_DEAD_DEAD_DEAD;
    tick();
    bus_if.bus_rvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (if_rsp_valid || lsu_rsp_valid || arb_busy) quiet = 1'b0;
      tick();
    end
    total++;
    if (quiet !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_no_rsp: got activity=%b required 0", !quiet);
    end
    if_req   = 1'b1;
    lsu_req  = 1'b1;
    sb_q.push_back('{lsu: 1'b1, rdata: 64'h0123_4567_89AB_CDEF, err: 1'b0});
    serve(0, 0, 64'h0123_4567_89AB_CDEF);
    if_req  = 1'b0;
    lsu_req = 1'b0;
    e = sb_q.pop_front();
    total++;
    if ({r_done, r_lsu, r_if, r_rdata} !== {1'b1, e.lsu, !e.lsu, e.rdata}) begin
      bad++;
      $display("FAIL reset_mid_first_contention: got done=%b lsu=%b if=%b rdata=%h required lsu rdata=%h",
               r_done, r_lsu, r_if, r_rdata, e.rdata);
    end
  endtask

  initial begin
    rst               = 1'b1;
    if_req            = 1'b0;
    if_addr           = '0;
    lsu_req           = 1'b0;
    lsu_addr          = '0;
    lsu_wen           = 1'b0;
    lsu_size          = '0;
    lsu_wdata         = '0;
    lsu_wmask         = '0;
    bus_if.bus_ready  = 1'b0;
    bus_if.bus_rvalid = 1'b0;
    bus_if.bus_rdata  = '0;
    test_reset();
    test_if_fetch();
    test_lsu_store();
    test_zero_wait();
    test_contention();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_arb.md
# mem_arb

Two-requester memory arbiter that shares the core's single memory bus port between instruction fetch (IF) and the load/store unit (LSU). The LSU is driven by the decoder's mem_rd_ena/mem_wr_ena and load/save info. The block grants one requester at a time and drives a valid/ready address phase. It tracks the outstanding access until the bus response, returns a registered response to the owner, and enforces a response timeout. It sits between the IF/MEM stages and the external memory bus.

## Interface
Parameters:
- TIMEOUT, 255, maximum cycles in WAIT before an error response; 0 disables the timeout.

Ports:
- clk  in  1  core clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  IF request; held high with if_addr stable until if_rsp_valid.
- if_addr  in  64  fetch address.
- if_rsp_valid  out  1  one-cycle pulse: IF response.
- if_rsp_rdata  out  64  bus read data for IF.
- if_rsp_err  out  1  IF access timed out; valid with if_rsp_valid.
- lsu_req  in  1  LSU request; all lsu_* fields held stable until lsu_rsp_valid.
- lsu_addr  in  64  load/store address.
- lsu_wen  in  1  1 = store, 0 = load.
- lsu_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword.
- lsu_wdata  in  64  store data.
- lsu_wmask  in  8  store byte mask.
- lsu_rsp_valid  out  1  one-cycle pulse: LSU response (load data or store ack).
- lsu_rsp_rdata  out  64  bus read data for LSU.
- lsu_rsp_err  out  1  LSU access timed out.
- bus_valid  out  1  address phase valid.
- bus_ready  in  1  bus accepts the address phase.
- bus_addr  out  64  access address.
- bus_wen  out  1  write enable.
- bus_size  out  2  access size.
- bus_wdata  out  64  write data.
- bus_wmask  out  8  write byte mask.
- bus_rvalid  in  1  response: read data valid, or write ack.
- bus_rdata  in  64  read data.
- arb_busy  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, ADDR, WAIT, RESP.
- IDLE, no request: stay in IDLE.
- IDLE, one or both requests:
  - Pick the owner.
  - Latch owner, address, wen, size, wdata and wmask into registers.
  - Go to ADDR.
- Owner selection:
  - Only one requester asserting: it wins.
  - Both asserting: LSU wins, unless the last completed grant went to LSU, in which case IF wins. This alternates under contention; neither side starves.
  - last_owner resets to IF, so LSU wins the first contention.
- Fields driven for an IF grant: bus_wen = 0, bus_size = 2, bus_wmask = 0, bus_wdata = 0.
- ADDR:
  - bus_valid = 1 and all bus_* fields come from the latched registers.
  - Stay until bus_ready.
  - bus_ready without bus_rvalid: go to WAIT and clear the timeout counter.
  - bus_ready with bus_rvalid in the same cycle: capture bus_rdata and go to RESP.
  - No timeout applies in ADDR. The address phase is never withdrawn.
- WAIT:
  - bus_valid = 0; the counter increments each cycle.
  - bus_rvalid: capture bus_rdata, err = 0, go to RESP.
  - Counter reaches TIMEOUT (TIMEOUT ≠ 0) without bus_rvalid: rdata = 0, err = 1, go to RESP.
  - rvalid and the timeout in the same cycle: rvalid wins.
- RESP:
  - Pulse the owner's rsp_valid for exactly one cycle with the captured rdata and err.
  - The non-owner's rsp_valid stays 0.
  - Update last_owner and go to IDLE.
- Stray inputs:
  - bus_rvalid in IDLE or RESP (a late response after a timeout) is ignored.
  - Requests are sampled only in IDLE.
- Read data is returned unmodified. The requester extracts the byte, half or word.

## Timing
- Reset values: state = IDLE, last_owner = IF, counter = 0. Every output is 0, including bus_* fields and both rsp_rdata.
- Reset mid-operation discards any in-flight access with no response. A later bus_rvalid is ignored.
- bus_valid rises the cycle after the request is sampled in IDLE; the address/control outputs are registered.
- Minimum latency, with ready and rvalid in the same cycle: request sampled at cycle 0, bus_valid at cycle 1, rsp_valid at cycle 2.
- Typical latency: bus_ready at cycle 1 and bus_rvalid at cycle k gives rsp_valid at k+1 and IDLE at k+2.
- A request still high at k+2 is treated as a new request. Back-to-back accesses have a 3-cycle minimum spacing.
- Timeout: err response at cycle w+TIMEOUT+1, where w is the first WAIT cycle. The counter is 8 bits wide, or wider if needed to hold TIMEOUT.
- rsp data outputs hold their value until the next RESP. Only rsp_valid is pulsed.

## Test plan
- IF-only fetch:
  - Stimulus: if_addr = 0x80000000; bus_ready at cycle 1, bus_rvalid at cycle 3 with rdata = 0x00000013_00000093.
  - Required: bus_size = 2, bus_wen = 0; if_rsp_valid at cycle 4 with that data and err = 0; lsu_rsp_valid stays 0.
- LSU store:
  - Stimulus: addr = 0x80001008, size = 3, wdata = 0xDEADBEEF_CAFEF00D, wmask = 0xFF.
  - Required: the bus fields match exactly while bus_valid is high. bus_valid holds across 3 cycles with bus_ready low. lsu_rsp_valid pulses one cycle after the ack.
- Contention:
  - Stimulus: if_req and lsu_req both held high from reset.
  - Required: grants go LSU, IF, LSU, IF.
  - Stimulus: an IF-only access followed by simultaneous requests.
  - Required: LSU wins.
- Zero-wait bus:
  - Stimulus: bus_ready and bus_rvalid both high in the first ADDR cycle.
  - Required: rsp_valid 2 cycles after the request is sampled.
- Timeout, with TIMEOUT = 4:
  - Stimulus: an LSU load that never receives rvalid.
  - Required: lsu_rsp_valid with err = 1 and rdata = 0, then IDLE. A late bus_rvalid is ignored, and the next IF request completes normally.
- Reset mid-operation:
  - Stimulus: rst pulsed high for 1 cycle during WAIT.
  - Required: all outputs 0 in the following cycle. No rsp_valid is issued for the aborted access. The first contention after reset goes to LSU.
